io_port_bank: RTL and testbench

- Parametrised successor to the CPU's fixed four 8-bit input/output ports (Pe0..Pe3 / ps0..ps3).
- Bank of N input channels and N output channels, each W bits wide, accessed by the CPU through one address/strobe interface.
- Input channels are synchronised and change-detected; sticky change flags and an interrupt line let the CPU stop busy-polling operands.
- Output channels are registered latches written by the CPU.

---
 rtl/io_port_bank_if.sv | 22 ++
 rtl/io_port_bank.sv | 122 ++++++++++++
 tb/tb_io_port_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_bank_if.sv
// rtl/io_port_bank_if.sv - CPU register-access bus for io_port_bank (address, strobes, write/read data)
interface io_port_bank_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic [AW-1:0] addr;
    logic          rd_en;
    logic          wr_en;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          rd_valid;

    modport master (
        output addr, rd_en, wr_en, wdata,
        input  rdata, rd_valid
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata,
        output rdata, rd_valid
    );
endinterface

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - N synchronised change-detected input channels, N output latches; optional irq mask via IO_PORT_BANK_IRQ_MASK_EN
module io_port_bank #(
    parameter int W           = 8,
    parameter int N           = 4,
    parameter int AW          = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*W-1:0]     pe,
    output logic [N*W-1:0]     ps,
    io_port_bank_if.slave      bus,
    output logic [N-1:0]       chg_flags,
    output logic               irq
);

    localparam int ACW = $clog2(SYNC_STAGES + 2);

    logic [N*W-1:0] sync_q [SYNC_STAGES];
    logic [N*W-1:0] s_flat;
    logic [N*W-1:0] prev_q;
    logic [ACW-1:0] arm_cnt_q;
    logic           armed_q;
    logic [N-1:0]   flags_q, flags_d;
    logic [N-1:0]   set_vec, clr_vec;
    logic [N*W-1:0] ps_q, ps_d;
    logic [W-1:0]   rdata_q, rd_mux;
    logic           rd_valid_q;
    logic           irq_q, irq_d;
`ifdef IO_PORT_BANK_IRQ_MASK_EN
    logic [N-1:0]   mask_q, mask_d;
`endif

    assign s_flat = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser chain for every input channel; pe is asynchronous to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= pe;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Hold off change detection until the synchroniser has flushed its reset zeros,
    // so the first real input values are not reported as changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            arm_cnt_q <= arm_cnt_q + ACW'(1);
            if (arm_cnt_q == ACW'(SYNC_STAGES)) armed_q <= 1'b1;
        end
    end

    // Decode reads/writes, compute flag set/clear and next output-channel state.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        rd_mux  = '0;
        ps_d    = ps_q;
`ifdef IO_PORT_BANK_IRQ_MASK_EN
        mask_d  = mask_q;
`endif
        for (int i = 0; i < N; i++) begin
            set_vec[i] = armed_q && (s_flat[i*W +: W] != prev_q[i*W +: W]);
            if (bus.addr == AW'(i)) begin
                rd_mux     = s_flat[i*W +: W];
                clr_vec[i] = bus.rd_en;
                if (bus.wr_en) ps_d[i*W +: W] = bus.wdata;
            end
        end
        if (bus.addr == AW'(N)) rd_mux[N-1:0] = flags_q;
`ifdef IO_PORT_BANK_IRQ_MASK_EN
        if (bus.addr == AW'(N + 1)) begin
            rd_mux[N-1:0] = mask_q;
            if (bus.wr_en) mask_d = bus.wdata[N-1:0];
        end
        irq_d = |(flags_q & mask_q);
`else
        irq_d = |flags_q;
`endif
        // A set on the same edge as a read-clear must win so no change is lost.
        flags_d = (flags_q & ~clr_vec) | set_vec;
    end

    // Register all CPU-visible state: flags, previous values, outputs, read data, irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            flags_q    <= '0;
            ps_q       <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= s_flat;
            flags_q    <= flags_d;
            ps_q       <= ps_d;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rdata_q <= rd_mux;
            irq_q      <= irq_d;
        end
    end

`ifdef IO_PORT_BANK_IRQ_MASK_EN
    // Interrupt mask; every channel enabled out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '1;
        else        mask_q <= mask_d;
    end
`endif

    assign ps           = ps_q;
    assign chg_flags    = flags_q;
    assign irq          = irq_q;
    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - scoreboard bench for io_port_bank with directed vectors
module tb_io_port_bank;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int SS = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N*W-1:0] pe = '0;
    logic [N*W-1:0] ps;
    logic [N-1:0]   chg_flags;
    logic           irq;

    io_port_bank_if #(.W(W), .AW(AW)) bus ();

    io_port_bank #(.W(W), .N(N), .AW(AW), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .pe        (pe),
        .ps        (ps),
        .bus       (bus),
        .chg_flags (chg_flags),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q [$];
    logic valid_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe(input int ch, input logic [W-1:0] v);
        pe[ch*W +: W] = v;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] exp);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Monitor: compare every read response against the scoreboard queue.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            n_cmp++;
            if (valid_prev) begin
                n_bad++;
                $display("FAIL rd_valid_pulse: got 2 consecutive cycles expected 1");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got rdata 0x%0h expected no response", bus.rdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.rdata !== e) begin
                    n_bad++;
                    $display("FAIL rdata: got 0x%0h expected 0x%0h", bus.rdata, e);
                end
            end
        end
        valid_prev = bus.rd_valid;
    end

    initial begin
        bus.addr  = '0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.wdata = '0;
        set_pe(0, 8'h06);
        set_pe(1, 8'h05);
        repeat (3) tick();
        check("rst_ps", ps, 0);
        check("rst_flags", chg_flags, 0);
        check("rst_irq", irq, 0);
        check("rst_rd_valid", bus.rd_valid, 0);

        // Release reset and let the arm window pass with non-zero inputs.
        reset = 1'b1;
        repeat (10) tick();
        check("arm_flags", chg_flags, 0);
        check("arm_irq", irq, 0);
        check("arm_ps", ps, 0);
        do_read(3'd1, 8'h05);
        tick();
        do_read(3'd0, 8'h06);
        tick();

        // ch1 change 0x05 -> 0x07 sets flag within SYNC_STAGES+2 cycles.
        set_pe(1, 8'h07);
        repeat (SS + 2) tick();
        check("chg1_flags", chg_flags, 4'b0010);
        check("chg1_irq", irq, 1);
        do_read(3'd1, 8'h07);
        check("clr1_flags", chg_flags, 0);
        check("clr1_irq_lag", irq, 1);
        tick();
        check("clr1_irq", irq, 0);

        // ch1 set event coincides with its read-clear: set wins.
        set_pe(1, 8'h03);
        tick();
        tick();
        do_read(3'd1, 8'h03);
        check("setwins_flags", chg_flags, 4'b0010);
        tick();
        do_read(3'd1, 8'h03);
        check("setwins_clr", chg_flags, 0);
        tick();

        // Output latches.
        do_write(3'd1, 8'h33);
        do_write(3'd2, 8'h44);
        do_write(3'd3, 8'h2A);
        do_write(3'd0, 8'h11);
        check("ps_writes", ps, 32'h2A443311);
        do_write(3'd7, 8'hFF);
        do_write(3'd4, 8'hFF);
        check("ps_unmapped_wr", ps, 32'h2A443311);
        do_read(3'd7, 8'h00);
        tick();
        do_read(3'd4, 8'h00);
        tick();
`ifdef IO_PORT_BANK_IRQ_MASK_EN
        do_read(3'd5, 8'h0F);
`else
        do_read(3'd5, 8'h00);
`endif
        tick();

        // Simultaneous read and write to addr 0: read sees input, write hits output.
        bus.addr  = 3'd0;
        bus.wdata = 8'h5A;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        exp_q.push_back(8'h06);
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("rdwr_ps", ps, 32'h2A44335A);
        tick();

        // Two channels changing together, status read does not clear.
        set_pe(2, 8'h80);
        set_pe(3, 8'h01);
        repeat (SS + 2) tick();
        check("chg23_flags", chg_flags, 4'b1100);
        check("chg23_irq", irq, 1);
        do_read(3'd4, 8'h0C);
        check("status_noclr", chg_flags, 4'b1100);
        tick();
        do_read(3'd2, 8'h80);
        tick();
        do_read(3'd3, 8'h01);
        check("chg23_clr", chg_flags, 0);
        tick();

        // Reset pulsed mid-cycle during a write: aborts, clears outputs immediately.
        bus.addr  = 3'd2;
        bus.wdata = 8'h55;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ps", ps, 0);
        check("midrst_rd_valid", bus.rd_valid, 0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tick();
        check("midrst_ps_hold", ps, 0);
        check("midrst_flags", chg_flags, 0);
        reset = 1'b1;
        repeat (10) tick();
        check("rearm_flags", chg_flags, 0);
        check("rearm_irq", irq, 0);

`ifdef IO_PORT_BANK_IRQ_MASK_EN
        do_write(3'd5, 8'h0D);
        do_read(3'd5, 8'h0D);
        set_pe(1, 8'h09);
        repeat (SS + 2) tick();
        check("mask_flags", chg_flags, 4'b0010);
        check("mask_irq_off", irq, 0);
        set_pe(0, 8'h01);
        repeat (SS + 2) tick();
        check("mask_flags2", chg_flags, 4'b0011);
        check("mask_irq_on", irq, 1);
`endif

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
